// File: rtl/cnn_accel.sv
// cnn_accel: two-kernel 3x3 convolution engine for the first CNN layer.
//
// A weight RAM of WEIGHT_DEPTH 72-bit kernel words is loaded over a write
// port. While sta is high, one pixel column per cycle shifts into a 3-column
// window. Each complete window is convolved with the kernel pair
// (2*kp, 2*kp+1) that was active when the window's last column arrived. Two
// saturated 8-bit results are registered one edge after that column.
//
// Build option: define CNN_RELU_EN for unsigned ReLU outputs clamped to
// 0..255. Without it, outputs are two's complement clamped to -128..127.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset
//   write_en in   1   weight RAM write strobe
//   addr_w   in  10   weight RAM write address (>= WEIGHT_DEPTH ignored)
//   data_w   in  72   kernel word, [71:64]=k(0,0) ... [7:0]=k(2,2), signed
//   scan_i   in  40   pixel column [23:16] top, [15:8] mid, [7:0] bottom
//   bias_i   in  24   [7:0] bias ch1, [15:8] bias ch2, [20:16] shift
//   sta      in   1   streaming run enable
//   valid_o  out  1   data outputs valid this cycle
//   data1_o  out  8   channel-1 result (kernel 2*kp)
//   data2_o  out  8   channel-2 result (kernel 2*kp+1)
module cnn_accel #(
    parameter int ROW_LEN      = 18,
    parameter int KERNEL_PAIRS = 288,
    parameter int WEIGHT_DEPTH = 576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [9:0]  addr_w,
    input  logic [71:0] data_w,
    input  logic [39:0] scan_i,
    input  logic [23:0] bias_i,
    input  logic        sta,
    output logic        valid_o,
    output logic [7:0]  data1_o,
    output logic [7:0]  data2_o
);

    localparam int CW  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
    localparam int KPW = (KERNEL_PAIRS > 1) ? $clog2(KERNEL_PAIRS) : 1;

    logic [71:0]    r_wram [WEIGHT_DEPTH];

    logic [CW-1:0]  r_col;
    logic [KPW-1:0] r_kp;
    logic [23:0]    r_win0;     // oldest (left) column
    logic [23:0]    r_win1;
    logic [23:0]    r_win2;     // newest (right) column
    logic           r_wvalid;   // window holds a complete 3x3 patch
    logic [KPW-1:0] r_wkp;      // kernel pair captured with the window
    logic [20:0]    r_bias;     // bias/shift captured with the window

    logic           r_valid;
    logic [7:0]     r_data1;
    logic [7:0]     r_data2;

    logic [71:0]    w_pix;
    logic [71:0]    w_k1;
    logic [71:0]    w_k2;
    logic [7:0]     w_res1;
    logic [7:0]     w_res2;
    logic           w_addr_ok;
    logic           w_unused;

    assign w_unused  = ^{scan_i[39:24], bias_i[23:21]};
    assign w_addr_ok = ({1'b0, addr_w} < 11'(WEIGHT_DEPTH));

    // Window flattened in the same row-major order as the kernel word.
    assign w_pix = {r_win0[23:16], r_win1[23:16], r_win2[23:16],
                    r_win0[15:8],  r_win1[15:8],  r_win2[15:8],
                    r_win0[7:0],   r_win1[7:0],   r_win2[7:0]};

    assign w_k1 = r_wram[{r_wkp, 1'b0}];
    assign w_k2 = r_wram[{r_wkp, 1'b1}];

    function automatic logic [7:0] f_conv(input logic [71:0] pix,
                                          input logic [71:0] kern,
                                          input logic [7:0]  bias,
                                          input logic [4:0]  sh);
        logic signed [19:0] sum;
        logic signed [19:0] shd;
        logic signed [20:0] t;
        logic signed [8:0]  p;
        logic signed [7:0]  w;
        logic signed [16:0] prod;
        sum = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            p    = {1'b0, pix[i*8 +: 8]};
            w    = kern[i*8 +: 8];
            prod = p * w;
            sum  = sum + 20'(prod);
        end
        shd = sum >>> sh;
        t   = 21'(shd) + 21'($signed(bias));
`ifdef CNN_RELU_EN
        if (t < 21'sd0)
            return 8'd0;
        else if (t > 21'sd255)
            return 8'd255;
        else
            return t[7:0];
`else
        if (t < -21'sd128)
            return 8'h80;
        else if (t > 21'sd127)
            return 8'h7F;
        else
            return t[7:0];
`endif
    endfunction

    assign w_res1 = f_conv(w_pix, w_k1, r_bias[7:0],  r_bias[20:16]);
    assign w_res2 = f_conv(w_pix, w_k2, r_bias[15:8], r_bias[20:16]);

    // Weight RAM: no reset, writes independent of streaming. A read at the
    // same edge as a write sees the old word.
    always_ff @(posedge clk) begin
        if (write_en && w_addr_ok)
            r_wram[addr_w] <= data_w;
    end

    // Column capture, column counter and kernel-pair pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col    <= '0;
            r_kp     <= '0;
            r_win0   <= '0;
            r_win1   <= '0;
            r_win2   <= '0;
            r_wvalid <= 1'b0;
            r_wkp    <= '0;
            r_bias   <= '0;
        end else if (sta) begin
            r_win0   <= r_win1;
            r_win1   <= r_win2;
            r_win2   <= scan_i[23:0];
            r_wvalid <= (r_col >= CW'(2));
            r_wkp    <= r_kp;
            r_bias   <= bias_i[20:0];
            if (r_col == CW'(ROW_LEN - 1)) begin
                r_col <= '0;
                if (r_kp == KPW'(KERNEL_PAIRS - 1))
                    r_kp <= '0;
                else
                    r_kp <= r_kp + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else begin
            r_col    <= '0;
            r_kp     <= '0;
            r_win0   <= '0;
            r_win1   <= '0;
            r_win2   <= '0;
            r_wvalid <= 1'b0;
        end
    end

    // Result register. A pending window is discarded when sta is low so that
    // valid_o is already 0 after the first idle edge; data holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data1 <= '0;
            r_data2 <= '0;
        end else if (sta && r_wvalid) begin
            r_valid <= 1'b1;
            r_data1 <= w_res1;
            r_data2 <= w_res2;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign valid_o = r_valid;
    assign data1_o = r_data1;
    assign data2_o = r_data2;

endmodule

// File: tb/tb_cnn_accel.sv
// tb_cnn_accel: directed bench for cnn_accel with a reference model and an
// expected-result queue. Expected results are pushed on the edge where a
// window is computed and popped whenever valid_o is seen high.
module tb_cnn_accel;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic [9:0]  addr_w;
    logic [71:0] data_w;
    logic [39:0] scan_i;
    logic [23:0] bias_i;
    logic        sta;
    logic        valid_o;
    logic [7:0]  data1_o;
    logic [7:0]  data2_o;

    cnn_accel #(
        .ROW_LEN      (18),
        .KERNEL_PAIRS (288),
        .WEIGHT_DEPTH (576)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write_en (write_en),
        .addr_w   (addr_w),
        .data_w   (data_w),
        .scan_i   (scan_i),
        .bias_i   (bias_i),
        .sta      (sta),
        .valid_o  (valid_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;
    int v_seen  = 0;

    // Reference model state
    logic [71:0] m_ram [576];
    int          m_col = 0;
    int          m_kp  = 0;
    logic [23:0] m_w0 = '0, m_w1 = '0, m_w2 = '0;
    logic        m_pv  = 1'b0;
    int          m_pkp = 0;
    logic [23:0] m_pb  = '0;
    logic [7:0]  m_hold1 = '0, m_hold2 = '0;
    logic [15:0] q_exp [$];

    function automatic logic [7:0] ref_ch(input logic [23:0] c0, input logic [23:0] c1,
                                          input logic [23:0] c2, input logic [71:0] k,
                                          input logic [7:0] b, input logic [4:0] sh);
        int sum;
        int t;
        logic [23:0] col;
        logic [7:0]  px;
        logic signed [7:0] wb;
        logic signed [7:0] bs;
        sum = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                col = (c == 0) ? c0 : ((c == 1) ? c1 : c2);
                px  = col[23-8*r -: 8];
                wb  = k[71-8*(3*r+c) -: 8];
                sum = sum + int'(px) * int'(wb);
            end
        end
        bs = b;
        t  = (sum >>> sh) + int'(bs);
`ifdef CNN_RELU_EN
        if (t < 0)   t = 0;
        if (t > 255) t = 255;
`else
        if (t < -128) t = -128;
        if (t > 127)  t = 127;
`endif
        return 8'(t);
    endfunction

    // One clock: drive inputs, advance the model, then check after the edge.
    task automatic cyc(input logic s, input logic [23:0] px, input logic [23:0] b,
                       input logic we, input logic [9:0] wa, input logic [71:0] wd);
        logic        ev;
        logic [15:0] e;
        sta      = s;
        scan_i   = {16'($urandom()), px};
        bias_i   = b;
        write_en = we;
        addr_w   = wa;
        data_w   = wd;
        ev = 1'b0;
        if (rst) begin
            m_col = 0; m_kp = 0; m_w0 = '0; m_w1 = '0; m_w2 = '0;
            m_pv = 1'b0; m_hold1 = '0; m_hold2 = '0;
            q_exp.delete();
        end else begin
            if (s && m_pv) begin
                ev = 1'b1;
                e = {ref_ch(m_w0, m_w1, m_w2, m_ram[2*m_pkp],   m_pb[7:0],  m_pb[20:16]),
                     ref_ch(m_w0, m_w1, m_w2, m_ram[2*m_pkp+1], m_pb[15:8], m_pb[20:16])};
                q_exp.push_back(e);
            end
            if (s) begin
                m_pv  = (m_col >= 2);
                m_pkp = m_kp;
                m_pb  = b;
                m_w0  = m_w1; m_w1 = m_w2; m_w2 = px;
                if (m_col == 17) begin
                    m_col = 0;
                    m_kp  = (m_kp == 287) ? 0 : m_kp + 1;
                end else begin
                    m_col = m_col + 1;
                end
            end else begin
                m_col = 0; m_kp = 0; m_w0 = '0; m_w1 = '0; m_w2 = '0;
                m_pv = 1'b0;
            end
        end
        if (we && int'(wa) < 576) m_ram[wa] = wd;

        @(posedge clk);
        #1;
        n_cyc++;

        n_tests++;
        assert (valid_o === ev) else begin
            n_fail++;
            $error("FAIL valid cyc=%0d observed=%0b expected=%0b", n_cyc, valid_o, ev);
            q_exp.delete();
        end
        if (valid_o === 1'b1) begin
            v_seen++;
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_empty cyc=%0d observed=valid expected=no_result", n_cyc);
            end else begin
                e = q_exp.pop_front();
                n_tests++;
                assert (data1_o === e[15:8]) else begin
                    n_fail++;
                    $error("FAIL data1 cyc=%0d observed=%0d expected=%0d", n_cyc, data1_o, e[15:8]);
                end
                n_tests++;
                assert (data2_o === e[7:0]) else begin
                    n_fail++;
                    $error("FAIL data2 cyc=%0d observed=%0d expected=%0d", n_cyc, data2_o, e[7:0]);
                end
                m_hold1 = e[15:8];
                m_hold2 = e[7:0];
            end
        end else begin
            n_tests++;
            assert (data1_o === m_hold1 && data2_o === m_hold2) else begin
                n_fail++;
                $error("FAIL hold cyc=%0d observed=%0h/%0h expected=%0h/%0h",
                       n_cyc, data1_o, data2_o, m_hold1, m_hold2);
            end
        end
    endtask

    task automatic stream(input int n, input bit rnd, input logic [23:0] px,
                          input logic [23:0] b, input bit rb);
        logic [23:0] p;
        logic [23:0] bb;
        for (int i = 0; i < n; i++) begin
            p  = rnd ? 24'($urandom()) : px;
            bb = rb ? {3'($urandom()), 5'($urandom_range(10, 6)), 16'($urandom())} : b;
            cyc(1'b1, p, bb, 1'b0, '0, '0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 24'($urandom()), '0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [9:0] a, input logic [71:0] d);
        cyc(1'b0, 24'($urandom()), '0, 1'b1, a, d);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; sta = 1'b0; write_en = 1'b0; addr_w = '0;
        data_w = '0; scan_i = '0; bias_i = '0;

        // Reset held for 3 cycles while streaming is requested
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 24'($urandom()), '0, 1'b0, '0, '0);
        rst = 1'b0;
        idle(1);

        // Load every weight word; an out-of-range write must be dropped
        for (int a = 0; a < 576; a++)
            wr(10'(a), {$urandom(), $urandom(), 8'($urandom())});
        wr(10'd578, {$urandom(), $urandom(), 8'($urandom())});

        // Basic convolution
        wr(10'd0, 72'h010101010101010101);
        wr(10'd1, 72'h000000000200000000);
        stream(19, 1'b0, 24'h0A0A0A, 24'h000000, 1'b0);
        idle(1);
        chk("basic_d1", data1_o, 8'd90);
        chk("basic_d2", data2_o, 8'd20);

        // Shift and bias
        wr(10'd0, {9{8'h01}});
        wr(10'd1, {9{8'h01}});
        stream(19, 1'b0, 24'h646464, 24'h02FB05, 1'b0);
        idle(1);
`ifdef CNN_RELU_EN
        chk("shbias_d1", data1_o, 8'd230);
        chk("shbias_d2", data2_o, 8'd220);
`else
        chk("shbias_d1", data1_o, 8'd127);
        chk("shbias_d2", data2_o, 8'd127);
`endif

        // Saturation
        wr(10'd0, {9{8'h7F}});
        wr(10'd1, {9{8'h80}});
        stream(19, 1'b0, 24'hFFFFFF, 24'h000000, 1'b0);
        idle(1);
`ifdef CNN_RELU_EN
        chk("sat_d1", data1_o, 8'd255);
        chk("sat_d2", data2_o, 8'd0);
`else
        chk("sat_d1", data1_o, 8'h7F);
        chk("sat_d2", data2_o, 8'h80);
`endif

        // Row wrap: second row on addresses 2/3, one weight rewritten mid-stream
        wr(10'd2, 72'h010203040506070809);
        wr(10'd3, 72'hFF01FE02FD03FC04FB);
        v_seen = 0;
        stream(25, 1'b1, '0, '0, 1'b1);
        cyc(1'b1, 24'($urandom()), {3'b0, 5'd7, 16'h0000}, 1'b1, 10'd3, 72'h0302010003FEFD0201);
        stream(11, 1'b1, '0, '0, 1'b1);
        n_tests++;
        assert (v_seen === 32) else begin
            n_fail++;
            $error("FAIL rowwrap_count observed=%0d expected=32", v_seen);
        end
        idle(1);

        // Pair wrap: 288 rows, then row 289 back on addresses 0/1
        wr(10'd0, {$urandom(), $urandom(), 8'($urandom())});
        wr(10'd1, {$urandom(), $urandom(), 8'($urandom())});
        stream(288 * 18, 1'b1, '0, '0, 1'b1);
        stream(18, 1'b1, '0, '0, 1'b1);
        // Partial row on pair 1, then a one-cycle drop: next row restarts at pair 0
        stream(9, 1'b1, '0, '0, 1'b1);
        idle(1);
        stream(19, 1'b1, '0, '0, 1'b1);
        idle(1);

        n_tests++;
        assert (q_exp.size() === 0) else begin
            n_fail++;
            $error("FAIL sb_leftover observed=%0d expected=0", q_exp.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_accel.md
# cnn_accel

Two-kernel 3×3 convolution engine for the first CNN layer. It holds a 576×72-bit weight RAM that is loaded over a write port. It then takes a stream of pixel columns and produces two 8-bit feature outputs per cycle, one per kernel of the active kernel pair. It sits between the image scanner (column source) and the feature-map writer (output sink).

## Interface
- `ROW_LEN`, default 18: columns per image row; each row yields ROW_LEN−2 outputs.
- `KERNEL_PAIRS`, default 288: number of kernel pairs cycled through, one pair per row.
- `WEIGHT_DEPTH`, default 576: weight RAM entries (2×KERNEL_PAIRS).

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `write_en`  in  1  weight RAM write strobe.
- `addr_w`  in  10  weight RAM write address.
- `data_w`  in  72  kernel word: nine signed 8-bit weights, `[71:64]`=k(0,0) … `[7:0]`=k(2,2), row-major.
- `scan_i`  in  40  pixel column: `[23:16]` top, `[15:8]` middle, `[7:0]` bottom, all unsigned; `[39:24]` reserved and ignored.
- `bias_i`  in  24  `[7:0]` signed bias for channel 1, `[15:8]` signed bias for channel 2, `[20:16]` right-shift amount, `[23:21]` ignored.
- `sta`  in  1  run enable for streaming.
- `valid_o`  out  1  data outputs valid this cycle.
- `data1_o`  out  8  channel-1 result (kernel at address 2·kp).
- `data2_o`  out  8  channel-2 result (kernel at address 2·kp+1).

## Operation
**Weight RAM**
- Writes occur when `write_en`=1 and `addr_w`<WEIGHT_DEPTH; other addresses are ignored.
- Writes are accepted regardless of `sta`.
- The RAM is not reset.

**Streaming (`sta`=1)**
- Each cycle, `scan_i[23:0]` shifts into a 3-column window; the oldest column is the left column.
- Column counter `col` runs 0..ROW_LEN−1 and wraps.
- Kernel-pair pointer `kp` increments when `col` wraps, and wraps from KERNEL_PAIRS−1 to 0.
- A window is complete when the column just captured has `col`≥2. Complete windows are computed using the `kp` captured with that window.

**Arithmetic, per channel**
- sum = Σ pixel(unsigned 8) × weight(signed 8), accumulated in signed 20 bits.
- t = (sum >>> shift) + sign-extended bias.
- t is saturated to the output range (see Configuration).

**Idle (`sta`=0)**
- `col`, `kp` and the window clear to 0.
- `valid_o` goes to 0 on the next edge.
- Data outputs hold their last value.

**Other rules**
- If a weight is written during streaming, a computation at the same edge uses the old RAM contents.
- `bias_i` is sampled together with the window's final column.

## Timing
- Reset values: `valid_o`=0, `data1_o`=0, `data2_o`=0, `col`=0, `kp`=0, window=0.
- Reset during streaming aborts immediately; after `rst` falls, streaming restarts at `col`=0, `kp`=0.
- Latency: the column with `col`=c≥2 is captured at edge N. The result is registered at edge N+1, so `valid_o`=1 during cycle N+1.
- With `sta` rising before edge E0, the first `valid_o` follows edge E3.
- Each row gives ROW_LEN−2 consecutive valid cycles, then 2 invalid cycles while the next row refills the window.
- There is no back-pressure: the consumer must sample every valid cycle.

## Configuration
- `CNN_RELU_EN` defined: outputs are unsigned. t<0 → 0 and t>255 → 255 (ReLU with saturation).
- `CNN_RELU_EN` undefined: outputs are two's-complement, saturated to −128..127.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles while `sta`=1 → `valid_o`=0 and `data1_o`=`data2_o`=0 throughout.
- **Basic convolution:**
  - Setup: addr 0 = 0x010101010101010101, addr 1 = 0x000000000200000000, all pixels 10, `bias_i`=0.
  - Response: `data1_o`=90 and `data2_o`=20 on every valid cycle.
- **Shift and bias:**
  - Setup: kernel all 1, pixels 100, `bias_i`=0x02FB05 (shift 2, bias2=−5, bias1=+5).
  - Response: `data1_o`=230, `data2_o`=220.
- **Saturation (with `CNN_RELU_EN`):**
  - Setup: pixels 255; kernel 0 all 0x7F, kernel 1 all 0x80.
  - Response: `data1_o`=255, `data2_o`=0. Without the macro: 127 and −128 (0x80).
- **Row wrap:**
  - Stimulus: stream 36 columns with `sta` held high.
  - Response: 16 valid, 2 invalid, 16 valid. The second row uses addresses 2/3, verified with distinct kernels.
- **Pair wrap and idle:**
  - Stream 288 rows, then one more → row 289 uses addresses 0/1 again.
  - Drop `sta` for 1 cycle → `valid_o`=0 and the next row restarts at `kp`=0.
